// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and constants for the 4-digit multiplexed display scanner.
// Anode patterns are active-low, one per digit index; ANODE_OFF blanks all digits.
package display_pkg;

    typedef logic [1:0] digit_idx_t;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    localparam logic [3:0] ANODE_OFF = 4'b1111;
    localparam logic [3:0] BCD_MAX   = 4'd9;

    function automatic logic [3:0] anode_pattern(input digit_idx_t idx);
        logic [3:0] pat;
        case (idx)
            2'd3:    pat = 4'b0111;
            2'd2:    pat = 4'b1011;
            2'd1:    pat = 4'b1101;
            default: pat = 4'b1110;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Load handshake plus display drive bundle for display_scan_ctrl.
// master = producer of BCD values and display consumer; slave = the scanner.
interface display_scan_ctrl_if;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_bcd;
    logic [3:0]  brightness;
    logic        lz_blank_en;
    logic [3:0]  anode_activate;
    logic [3:0]  digit_bcd;
    logic        seg_blank;
    logic        frame_start;

    modport master (
        output load_valid, load_bcd, brightness, lz_blank_en,
        input  load_ready, anode_activate, digit_bcd, seg_blank, frame_start
    );

    modport slave (
        input  load_valid, load_bcd, brightness, lz_blank_en,
        output load_ready, anode_activate, digit_bcd, seg_blank, frame_start
    );
endinterface

// File: rtl/display_scan_ctrl_timer.sv
// Phase counter and BLANK/DRIVE/digit sequencing; all outputs decode current state (0 latency).
// Free-running, no backpressure: one slot = BLANK_CYCLES + DWELL_CYCLES clocks, digits 3->0.
module scan_timer
    import display_pkg::*;
#(
    parameter int DWELL_CYCLES = 262144,
    parameter int BLANK_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] bright,
    output logic       slot_first,
    output logic       drive_active,
    output logic       on_window,
    output logic       frame_last,
    output digit_idx_t digit_idx
);

    localparam int CW   = $clog2(DWELL_CYCLES > BLANK_CYCLES ? DWELL_CYCLES : BLANK_CYCLES);
    localparam int TW   = CW + 1;
    localparam int UNIT = DWELL_CYCLES / 16;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    scan_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    digit_idx_t    digit_q, digit_d;
    logic [TW-1:0] on_limit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        digit_d = digit_q;
        case (state_q)
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                end
            end
            DRIVE: begin
                if (cnt_q == DWELL_LAST) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    digit_d = digit_q - 1'b1;
                end
            end
            default: begin
                state_d = BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BLANK;
            cnt_q   <= '0;
            digit_q <= 2'd3;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
        end
    end

    // Duty window is (b+1)/16 of the dwell; limit can equal DWELL_CYCLES, hence the extra bit.
    assign on_limit     = TW'((int'(bright) + 1) * UNIT);
    assign slot_first   = (state_q == BLANK) && (cnt_q == '0);
    assign drive_active = (state_q == DRIVE);
    assign on_window    = (state_q == DRIVE) && ({1'b0, cnt_q} < on_limit);
    assign frame_last   = (state_q == DRIVE) && (cnt_q == DWELL_LAST) && (digit_q == 2'd0);
    assign digit_idx    = digit_q;

endmodule

// File: rtl/display_scan_ctrl.sv
// 4-digit 7-seg scan scheduler: shadow/active BCD registers committed at frame end, PWM, LZ blanking.
// Outputs lag timer state by 1 clock; load_ready is low while a value waits for the frame boundary.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int DWELL_CYCLES = 262144,
    parameter int BLANK_CYCLES = 1024
) (
    input  logic                clock_100Mhz,
    input  logic                reset_n,
    display_scan_ctrl_if.slave  bus
);

    logic       slot_first;
    logic       drive_active;
    logic       on_window;
    logic       frame_last;
    digit_idx_t digit_idx;

    logic [15:0] active_q, active_d;
    logic [15:0] shadow_q, shadow_d;
    logic        pend_q, pend_d;
    logic        ready_q, ready_d;
    logic        started_q, started_d;
    logic [3:0]  bright_q, bright_d;
    logic        lz_q, lz_d;
    logic [3:0]  anode_q, anode_d;
    logic [3:0]  digit_q, digit_d;
    logic        seg_q, seg_d;
    logic        fs_q, fs_d;

    logic [3:0]  nib;
    logic [3:0]  lz_zero;
    logic        digit_blank;
    logic        commit;

    scan_timer #(
        .DWELL_CYCLES (DWELL_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk          (clock_100Mhz),
        .rst_n        (reset_n),
        .bright       (bright_q),
        .slot_first   (slot_first),
        .drive_active (drive_active),
        .on_window    (on_window),
        .frame_last   (frame_last),
        .digit_idx    (digit_idx)
    );

    // lz_zero[k]: nibble k and every more-significant nibble are zero; digit 0 always shown.
    always_comb begin
        lz_zero[3] = (active_q[15:12] == 4'd0);
        lz_zero[2] = lz_zero[3] && (active_q[11:8] == 4'd0);
        lz_zero[1] = lz_zero[2] && (active_q[7:4] == 4'd0);
        lz_zero[0] = 1'b0;
    end

    assign nib         = active_q[{digit_idx, 2'b00} +: 4];
    assign digit_blank = (nib > BCD_MAX) || (lz_q && lz_zero[digit_idx]);
    assign commit      = frame_last || !started_q;

    always_comb begin
        active_d  = active_q;
        shadow_d  = shadow_q;
        pend_d    = pend_q;
        started_d = 1'b1;
        bright_d  = slot_first ? bus.brightness : bright_q;
        lz_d      = slot_first ? bus.lz_blank_en : lz_q;

        // ready_q mirrors !pend_q, so commit and capture never coincide.
        if (commit && pend_q) begin
            active_d = shadow_q;
            pend_d   = 1'b0;
        end
        if (bus.load_valid && ready_q) begin
            shadow_d = bus.load_bcd;
            pend_d   = 1'b1;
        end
        ready_d = !pend_d;

        anode_d = (on_window && !digit_blank) ? anode_pattern(digit_idx) : ANODE_OFF;
        seg_d   = !drive_active || digit_blank;
        digit_d = nib;
        fs_d    = slot_first && (digit_idx == 2'd3);
    end

    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            active_q  <= '0;
            shadow_q  <= '0;
            pend_q    <= 1'b0;
            ready_q   <= 1'b1;
            started_q <= 1'b0;
            bright_q  <= '0;
            lz_q      <= 1'b0;
            anode_q   <= ANODE_OFF;
            digit_q   <= '0;
            seg_q     <= 1'b1;
            fs_q      <= 1'b0;
        end else begin
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pend_q    <= pend_d;
            ready_q   <= ready_d;
            started_q <= started_d;
            bright_q  <= bright_d;
            lz_q      <= lz_d;
            anode_q   <= anode_d;
            digit_q   <= digit_d;
            seg_q     <= seg_d;
            fs_q      <= fs_d;
        end
    end

    assign bus.load_ready     = ready_q;
    assign bus.anode_activate = anode_q;
    assign bus.digit_bcd      = digit_q;
    assign bus.seg_blank      = seg_q;
    assign bus.frame_start    = fs_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl with DWELL=16, BLANK=2: frame-arithmetic model plus directed literals.
module tb_display_scan_ctrl;

    localparam int D     = 16;
    localparam int B     = 2;
    localparam int S     = D + B;
    localparam int FRAME = 4 * S;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    display_scan_ctrl_if bus();

    display_scan_ctrl #(
        .DWELL_CYCLES (D),
        .BLANK_CYCLES (B)
    ) dut (
        .clock_100Mhz (clk),
        .reset_n      (reset_n),
        .bus          (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model state; e = clock edges since reset release.
    int          e        = 0;
    int          b_cur    = 0;
    bit          lz_cur   = 1'b0;
    logic [15:0] m_active = '0;
    logic [15:0] m_shadow = '0;
    bit          m_pend   = 1'b0;
    logic [3:0]  x_anode  = 4'hF;
    logic [3:0]  x_digit  = 4'h0;
    logic        x_seg    = 1'b1;
    logic        x_ready  = 1'b1;
    logic        x_fs     = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (k=%0d t=%0t)", name, act, expv, e, $time);
        end
    endtask

    task automatic model_reset();
        e        = 0;
        b_cur    = 0;
        lz_cur   = 1'b0;
        m_active = '0;
        m_shadow = '0;
        m_pend   = 1'b0;
        x_anode  = 4'hF;
        x_digit  = 4'h0;
        x_seg    = 1'b1;
        x_ready  = 1'b1;
        x_fs     = 1'b0;
    endtask

    // Outputs after edge m+1 describe state cycle m: slot m/S, offset m%S, digit 3 - slot%4.
    task automatic model_step();
        int         m, o, s, d;
        logic [3:0] nib;
        bit         blk, old_pend;
        m = e;
        o = m % S;
        s = m / S;
        d = 3 - (s % 4);
        if (o == 0) begin
            b_cur  = int'(bus.brightness);
            lz_cur = bus.lz_blank_en;
        end
        nib = 4'((m_active >> (4 * d)) & 16'h000F);
        blk = (nib > 4'd9) || (lz_cur && d > 0 && ((m_active >> (4 * d)) == 16'h0000));
        x_fs    = (o == 0) && (d == 3);
        x_digit = nib;
        if (o < B) begin
            x_anode = 4'hF;
            x_seg   = 1'b1;
        end else begin
            x_seg   = blk;
            x_anode = (!blk && (o - B) < (b_cur + 1) * D / 16) ? ~(4'b0001 << d) : 4'hF;
        end
        old_pend = m_pend;
        if ((m % FRAME) == FRAME - 1 && old_pend) begin
            m_active = m_shadow;
            m_pend   = 1'b0;
        end
        if (bus.load_valid && !old_pend) begin
            m_shadow = bus.load_bcd;
            m_pend   = 1'b1;
        end
        x_ready = !m_pend;
        e = m + 1;
    endtask

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) model_reset();
        else          model_step();
    end

    initial forever begin
        @(negedge clk);
        check("anode_activate", bus.anode_activate, x_anode);
        check("digit_bcd",      bus.digit_bcd,      x_digit);
        check("seg_blank",      bus.seg_blank,      x_seg);
        check("load_ready",     bus.load_ready,     x_ready);
        check("frame_start",    bus.frame_start,    x_fs);
    end

    task automatic wait_k(input int t);
        int guard;
        guard = 0;
        while (e < t && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (e != t) begin
            errors++;
            $display("FAIL wait_k: edge count %0d, wanted %0d", e, t);
        end
    endtask

    task automatic count_low(input int first, input int last, output int n);
        n = 0;
        for (int k = first; k <= last; k++) begin
            wait_k(k);
            if (bus.anode_activate != 4'hF) n++;
        end
    endtask

    int c1, c2;

    initial begin
        bus.load_valid  = 1'b0;
        bus.load_bcd    = 16'h0000;
        bus.brightness  = 4'd15;
        bus.lz_blank_en = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Reset release, first frame of zeros.
        wait_k(1);  check("lit_fs_first", bus.frame_start, 1);
        wait_k(2);  check("lit_blank_gap", bus.anode_activate, 4'hF);
        wait_k(3);  check("lit_first_anode", bus.anode_activate, 4'b0111);
        wait_k(20); bus.load_valid = 1'b1; bus.load_bcd = 16'h1234;
        wait_k(21); check("lit_digit2_anode", bus.anode_activate, 4'b1011);
        bus.load_valid = 1'b0; bus.load_bcd = 16'hFFFF;
        check("lit_ready_low", bus.load_ready, 0);
        wait_k(57); check("lit_old_frame_d0", bus.digit_bcd, 0);
        wait_k(71); check("lit_ready_pre_commit", bus.load_ready, 0);
        wait_k(72); check("lit_ready_post_commit", bus.load_ready, 1);
        wait_k(75); check("lit_new_d3", bus.digit_bcd, 1);
        wait_k(93); check("lit_new_d2", bus.digit_bcd, 2);
        wait_k(111); check("lit_new_d1", bus.digit_bcd, 3);
        wait_k(129); check("lit_new_d0", bus.digit_bcd, 4);

        // Brightness 3, then 15 changed mid-DRIVE.
        wait_k(140); bus.brightness = 4'd3;
        count_low(145, 162, c1);
        check("lit_duty_b3", 16'(c1), 4);
        count_low(163, 168, c1);
        bus.brightness = 4'd15;
        count_low(169, 180, c2);
        check("lit_duty_midchange", 16'(c1 + c2), 4);
        count_low(181, 198, c1);
        check("lit_duty_b15", 16'(c1), 16);

        // Leading-zero suppression.
        wait_k(200); bus.lz_blank_en = 1'b1; bus.load_valid = 1'b1; bus.load_bcd = 16'h0050;
        wait_k(201); bus.load_valid = 1'b0;
        count_low(217, 234, c1);
        check("lit_lz_d3_dark", 16'(c1), 0);
        wait_k(236); bus.load_valid = 1'b1; bus.load_bcd = 16'h0000;
        wait_k(237); bus.load_valid = 1'b0;
        wait_k(240); check("lit_lz_d2_seg", bus.seg_blank, 1);
        check("lit_lz_d2_anode", bus.anode_activate, 4'hF);
        wait_k(256); check("lit_lz_d1_digit", bus.digit_bcd, 5);
        check("lit_lz_d1_seg", bus.seg_blank, 0);
        check("lit_lz_d1_anode", bus.anode_activate, 4'b1101);
        wait_k(274); check("lit_lz_d0_digit", bus.digit_bcd, 0);
        check("lit_lz_d0_anode", bus.anode_activate, 4'b1110);
        count_low(289, 306, c1);
        check("lit_zero_d3_dark", 16'(c1), 0);
        wait_k(310); bus.load_valid = 1'b1; bus.load_bcd = 16'h00A7;
        wait_k(311); bus.load_valid = 1'b0;
        count_low(343, 360, c1);
        check("lit_zero_d0_lit", 16'(c1), 16);
        wait_k(400); check("lit_hex_d1_seg", bus.seg_blank, 1);
        check("lit_hex_d1_anode", bus.anode_activate, 4'hF);
        wait_k(418); check("lit_hex_d0_digit", bus.digit_bcd, 7);
        check("lit_hex_d0_seg", bus.seg_blank, 0);

        // Back-to-back loads.
        wait_k(420); bus.lz_blank_en = 1'b0; bus.load_valid = 1'b1; bus.load_bcd = 16'h1111;
        wait_k(421); bus.load_bcd = 16'h2222;
        wait_k(431); check("lit_b2b_ready_low", bus.load_ready, 0);
        wait_k(432); check("lit_b2b_ready_high", bus.load_ready, 1);
        wait_k(433); check("lit_b2b_second_taken", bus.load_ready, 0);
        bus.load_valid = 1'b0;
        wait_k(436); check("lit_b2b_first_shown", bus.digit_bcd, 1);
        wait_k(490); check("lit_b2b_still_first", bus.digit_bcd, 1);
        wait_k(508); check("lit_b2b_second_shown", bus.digit_bcd, 2);

        // Asynchronous reset mid-DRIVE with a pending value.
        wait_k(520); bus.load_valid = 1'b1; bus.load_bcd = 16'h9876;
        wait_k(521); bus.load_valid = 1'b0;
        check("lit_pending_set", bus.load_ready, 0);
        wait_k(530); check("lit_pre_reset_anode", bus.anode_activate, 4'b1011);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("lit_rst_anode", bus.anode_activate, 4'hF);
        check("lit_rst_digit", bus.digit_bcd, 0);
        check("lit_rst_seg", bus.seg_blank, 1);
        check("lit_rst_ready", bus.load_ready, 1);
        check("lit_rst_fs", bus.frame_start, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        wait_k(1);  check("lit_rerun_fs", bus.frame_start, 1);
        check("lit_rerun_ready", bus.load_ready, 1);
        wait_k(5);  check("lit_rerun_anode", bus.anode_activate, 4'b0111);
        check("lit_rerun_digit", bus.digit_bcd, 0);
        wait_k(75); check("lit_rerun_discarded", bus.digit_bcd, 0);
        wait_k(2 * FRAME + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
